// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative RV32M multiply/divide sequencer for the EX stage.
// When an M-op sits in EX it latches operand magnitudes and sign flags, runs a
// 32-step shift-add (multiply) or restoring-divide loop, applies sign fix-up,
// and presents the result for one cycle while stall holds the front end.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          valid M-op in EX
//   funct3         op select (MUL..REMU)
//   op_a, op_b     forwarded rs1/rs2 values
//   stall          freeze IF/ID/ID_EX, bubble into EX_MEM (combinational)
//   busy           sequencer not idle
//   done           one-cycle pulse, result valid
//   result         operation result, held until the next completion
module ex_muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        fn;
    logic [XLEN-1:0]   mag_a;    // multiplicand (mul) / unused (div)
    logic [XLEN-1:0]   mag_b;    // divisor (div) / unused after load (mul)
    logic [2*XLEN-1:0] acc;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic              neg_res;  // product / quotient must be negated
    logic              neg_rem;  // remainder must be negated (dividend was negative)

    // Operand interpretation for the incoming op.
    logic            sgn_a, sgn_b, neg_a, neg_b, is_div, div_zero, div_ovf;
    logic [XLEN-1:0] abs_a, abs_b;

    always_comb begin
        sgn_a    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        sgn_b    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        neg_a    = sgn_a && op_a[XLEN-1];
        neg_b    = sgn_b && op_b[XLEN-1];
        abs_a    = neg_a ? (~op_a + 1'b1) : op_a;
        abs_b    = neg_b ? (~op_b + 1'b1) : op_b;
        is_div   = funct3[2];
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && !funct3[0] &&
                   (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    end

    // One iteration of each loop.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
        div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, mag_b};
        if (!fn[2])
            acc_step = {mul_sum, acc[XLEN-1:1]};
        else if (!div_trial[XLEN])
            acc_step = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_step = {acc[2*XLEN-2:0], 1'b0};
    end

    // Sign fix-up and output select.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    always_comb begin
        prod = neg_res ? (~acc + 1'b1) : acc;
        quo  = neg_res ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        rem  = neg_rem ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
        case (fn)
            3'b000:         fix_res = prod[XLEN-1:0];
            3'b100, 3'b101: fix_res = quo;
            3'b110, 3'b111: fix_res = rem;
            default:        fix_res = prod[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            fn      <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            acc     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    fn      <= funct3;
                    mag_a   <= abs_a;
                    mag_b   <= abs_b;
                    acc     <= {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
                    neg_res <= neg_a ^ neg_b;
                    neg_rem <= neg_a;
                    cnt     <= '0;
                    // Special cases bypass the loop and answer directly.
                    if (div_zero) begin
                        result <= funct3[1] ? op_a : '1;
                        state  <= S_DONE;
                    end else if (div_ovf) begin
                        result <= funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        state  <= S_DONE;
                    end else begin
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP)
                        state <= S_FIX;
                end
                S_FIX: begin
                    result <= fix_res;
                    state  <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A special case still stalls in its start cycle so EX_MEM takes a bubble.
    assign stall = ((state == S_IDLE) && start) || (state == S_CALC) || (state == S_FIX);
    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: hand-computed results, stall length,
// done latency, reset abort and back-to-back issue.
module tb_ex_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        stall, busy, done;
    logic [31:0] result;

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    ex_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .stall(stall), .busy(busy),
        .done(done), .result(result)
    );

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op (start rises just after a posedge: that is cycle 0), count
    // stall cycles up to done, check latency and result. Operands are
    // scrambled after cycle 0 to show they are latched.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input bit keep);
        int stall_n = 0;
        int dc = -1;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (stall) stall_n++;
            if (done) begin dc = c; break; end
            if (c == 1) begin op_a = ~a; op_b = b + 32'd3; funct3 = ~f; end
        end
        check({tag, " done_cycle"}, 32'(dc), 32'(exp_lat));
        check({tag, " stall_cycles"}, 32'(stall_n), 32'(exp_lat));
        check({tag, " result"}, result, exp_res);
        if (!keep) start = 1'b0;
        else begin funct3 = f; op_a = a; op_b = b; end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset stall", 32'(stall), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;

        run_op("MUL 7x-3",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 0);
        run_op("MULHU -1x-1",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0);
        run_op("MULH -1x-1",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34, 0);
        run_op("MULHSU -1x2",   3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, 0);
        run_op("DIV -7/2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 0);
        run_op("REM -7,2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 0);
        run_op("DIVU 100/7",    3'b101, 32'd100,      32'd7,        32'd14,       34, 0);
        run_op("REMU 100,7",    3'b111, 32'd100,      32'd7,        32'd2,        34, 0);
        run_op("DIVU 5/0",      3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  0);
        run_op("REMU 5,0",      3'b111, 32'd5,        32'd0,        32'd5,        1,  0);
        run_op("DIV ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0);
        run_op("REM ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  0);

        // Reset during CALC cycle 10 aborts without done.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b000; op_a = 32'd5; op_b = 32'd6;
        repeat (11) @(negedge clk);
        check("pre-abort busy", 32'(busy), 32'd1);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        check("abort stall", 32'(stall), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", result, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort no done", 32'(done_cnt), 32'd12);

        run_op("MUL 3x4",       3'b000, 32'd3,        32'd4,        32'd12,       34, 0);

        // Back-to-back with start held across DONE.
        run_op("b2b MUL 2x3",   3'b000, 32'd2,        32'd3,        32'd6,        34, 1);
        run_op("b2b DIVU 9/2",  3'b101, 32'd9,        32'd2,        32'd4,        34, 0);

        repeat (5) @(negedge clk);
        check("idle after b2b", 32'(busy), 32'd0);
        check("result held", result, 32'd4);
        check("total done pulses", 32'(done_cnt), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
Iterative multiply/divide sequencer for the EX stage, implementing the RV32M operations MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- When an M-extension op reaches EX, it latches the forwarded operands and runs a 32-step shift-add or restoring-divide loop.
- While the loop runs it holds `stall` high so that IF, ID and ID_EX freeze.
- When finished it presents the result for one cycle, so the EX->MEM register captures it in place of the ALU result.

Parameters:
- XLEN, 32, operand/result width (only 32 supported).
- CNT_W, 6, iteration counter width; must hold the value XLEN.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  valid M-op currently in EX (ID_EX M-op decode, qualified by no bubble).
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  32  rs1 value after forwarding.
- op_b  input  32  rs2 value after forwarding.
- stall  output  1  freeze IF/ID/ID_EX and insert a bubble into EX_MEM; combinational.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse: result valid this cycle.
- result  output  32  operation result.

Behaviour:
- Reset state (rst=1 at a clk edge), all applied next cycle:
  - state=IDLE; stall=0, busy=0, done=0, result=0.
  - Counter, operand, accumulator and sign registers cleared.
  - Reset mid-operation aborts without producing `done`.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - `start` ignored unless state==IDLE.
  - On start=1, latch funct3.
  - Latch magnitudes |op_a| and |op_b|. A value is treated as signed per op: MULH, DIV and REM treat both operands as signed; MULHSU treats only op_a as signed; all others are unsigned.
  - Latch result sign flags; counter=0.
  - Next state:
    - Divide-class with op_b==0: go to DONE. result = 0xFFFFFFFF for DIV/DIVU; result = op_a for REM/REMU.
    - DIV/REM with op_a==0x80000000 and op_b==0xFFFFFFFF: go to DONE. result = 0x80000000 for DIV; result = 0 for REM.
    - Otherwise go to CALC.
- CALC, one step per cycle, counter increments:
  - Multiply: 64-bit product accumulator, shift-add over the multiplier LSB.
  - Divide: restoring algorithm with a 33-bit partial-remainder subtract; quotient bit shifted in each step.
  - After step 32 (counter==31 on entry to that cycle) go to FIX.
- FIX, one cycle, conditional two's-complement negation:
  - Product: negate if the signs differ.
  - Quotient: negate if the signs differ.
  - Remainder: takes the sign of the dividend.
  - Select output: low word for MUL, high word for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
  - Register into `result`; go to DONE.
- DONE:
  - done=1, stall=0. `start` is still high for the same instruction and is ignored.
  - Unconditionally go to IDLE.
- stall = (state==IDLE && start && !special_case) || state==CALC || state==FIX.
  - A special case (divide by zero or overflow) still stalls for the start cycle: stall = start in IDLE regardless.
  - Final rule: stall = (IDLE && start) || CALC || FIX.
- Latency, start in cycle 0:
  - Normal op: CALC in cycles 1-32, FIX in cycle 33, DONE in cycle 34. stall high in cycles 0-33 (34 cycles); done in cycle 34.
  - Special case: stall only in cycle 0; done in cycle 1.
- Back-to-back M-ops: the second op is in EX the cycle after DONE and sees IDLE with start=1; no dead cycle is needed.
- `result` holds its value after DONE until the next completion.
- `done` never asserts without a preceding start; it never asserts twice per start.
- Operands are latched, so changes on op_a/op_b/funct3 after cycle 0 have no effect.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (-3) -> stall high for exactly 34 cycles; done in cycle 34; result=0xFFFFFFEB.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE. MULH same operands -> result=0x00000000. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7,2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100,7 -> 2.
- DIVU 5/0 -> done in cycle 1, result 0xFFFFFFFF. REMU 5,0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0. stall high for cycle 0 only.
- Assert rst in CALC cycle 10 -> next cycle state IDLE, stall=0, done=0, result=0. A following MUL 3x4 -> 12 with full 34-cycle latency.
- Back-to-back MUL 2x3 then DIVU 9/2 with start held -> first done=1 result=6; immediately the next cycle starts the second op; done 34 cycles later result=4; exactly two done pulses.
